// File: rtl/param_counter_pkg.sv
// Shared constants for param_updown_counter: run-mode encodings and direction values.
// Optional prescaler is selected by the PARAM_COUNTER_PRESCALE_EN macro in the top.
package param_counter_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_WRAP     = 2'b00;
    localparam mode_t MODE_SAT      = 2'b01;
    localparam mode_t MODE_ONESHOT  = 2'b10;
    localparam mode_t MODE_PINGPONG = 2'b11;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage : param_counter_pkg

// File: rtl/counter_prescaler.sv
// Clock-enable divider for param_updown_counter: one tick every DIV enabled clocks.
// Only compiled when PARAM_COUNTER_PRESCALE_EN is defined.
`ifdef PARAM_COUNTER_PRESCALE_EN
module counter_prescaler #(
    parameter int DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;

    // Tick on the last phase so the first tick lands DIV enabled clocks after a clear.
    assign tick = en && (div_cnt == LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (clr) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + CW'(1);
        end
    end

endmodule : counter_prescaler
`endif

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with wrap, saturate, one-shot and ping-pong modes.
// Define PARAM_COUNTER_PRESCALE_EN to gate steps through counter_prescaler.
module param_updown_counter
    import param_counter_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int MAX_VAL      = (2 ** WIDTH) - 1,
    parameter int PRESCALE_DIV = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             evt,
    output logic             done,
    output logic             dir
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    if (WIDTH < 2 || MAX_VAL < 1 || (WIDTH < 31 && MAX_VAL > (2 ** WIDTH) - 1) ||
        PRESCALE_DIV < 2) begin : g_param_check
        $error("param_updown_counter: illegal parameter combination");
    end

    logic             tick;
    logic             pp_dir;
    logic             step;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] count_nxt;
    logic             evt_nxt;
    logic             done_nxt;
    logic             pp_dir_nxt;

`ifdef PARAM_COUNTER_PRESCALE_EN
    counter_prescaler #(
        .DIV (PRESCALE_DIV)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .en    (en),
        .clr   (load),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign dir          = (mode == MODE_PINGPONG) ? pp_dir : up_dn;
    assign tc           = (dir == DIR_UP) ? (count == MAX_CNT) : (count == '0);
    assign step         = en && tick && !((mode == MODE_ONESHOT) && done);
    assign load_clamped = (load_val > MAX_CNT) ? MAX_CNT : load_val;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
        count_nxt  = count;
        evt_nxt    = 1'b0;
        done_nxt   = done;
        pp_dir_nxt = pp_dir;

        if (load) begin
            count_nxt  = load_clamped;
            done_nxt   = 1'b0;
            pp_dir_nxt = up_dn;
        end else if (step) begin
            if (!tc) begin
                count_nxt = (dir == DIR_UP) ? count + ONE : count - ONE;
            end else begin
                case (mode)
                    MODE_WRAP: begin
                        count_nxt = (dir == DIR_UP) ? '0 : MAX_CNT;
                        evt_nxt   = 1'b1;
                    end
                    MODE_SAT: begin
                        count_nxt = count;
                    end
                    MODE_ONESHOT: begin
                        done_nxt = 1'b1;
                        evt_nxt  = !done;
                    end
                    default: begin
                        // Bounce: reverse and take the first step of the new direction at once.
                        pp_dir_nxt = !pp_dir;
                        count_nxt  = (pp_dir == DIR_UP) ? MAX_CNT - ONE : ONE;
                        evt_nxt    = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values, independent of statement order.
        if (!reset) begin
            count  <= '0;
            evt    <= 1'b0;
            done   <= 1'b0;
            pp_dir <= DIR_UP;
        end else begin
            count  <= count_nxt;
            evt    <= evt_nxt;
            done   <= done_nxt;
            pp_dir <= pp_dir_nxt;
        end
    end

endmodule : param_updown_counter

// File: tb/tb_param_updown_counter.sv
// Directed self-checking bench for param_updown_counter, WIDTH=4, MAX_VAL=9, prescaler disabled.
`timescale 1ns/1ps
module tb_param_updown_counter;

    logic       clock = 1'b0;
    logic       reset;
    logic       en;
    logic       up_dn;
    logic [1:0] mode;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       tc;
    logic       evt;
    logic       done;
    logic       dir;

    int checks = 0;
    int errors = 0;

    param_updown_counter #(
        .WIDTH        (4),
        .MAX_VAL      (9),
        .PRESCALE_DIV (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .up_dn    (up_dn),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .evt      (evt),
        .done     (done),
        .dir      (dir)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one active edge and settle just after it.
    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int exp_cnt;
        int wrap_dn_cnt [3] = '{1, 0, 9};
        int sat_cnt     [5] = '{8, 9, 9, 9, 9};

        reset = 1'b0; en = 1'b0; up_dn = 1'b1; mode = 2'b00; load = 1'b0; load_val = 4'd0;
        #12;
        check("rst_count", count, 0);
        check("rst_evt",   evt,   0);
        check("rst_done",  done,  0);
        check("rst_dir",   dir,   1);
        reset = 1'b1;

        // Wrap up from 0 for 12 clocks.
        en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cycle();
            exp_cnt = i % 10;
            check($sformatf("wrap_up_cnt%0d", i), count, exp_cnt);
            check($sformatf("wrap_up_evt%0d", i), evt, (exp_cnt == 0));
            check($sformatf("wrap_up_tc%0d", i),  tc,  (exp_cnt == 9));
        end

        // Wrap down from 2: 1, 0, then wrap to 9.
        up_dn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check($sformatf("wrap_dn_cnt%0d", i), count, wrap_dn_cnt[i]);
            check($sformatf("wrap_dn_evt%0d", i), evt, (i == 2));
            check($sformatf("wrap_dn_tc%0d", i),  tc,  (i == 1));
        end

        // Saturate: load 7, then up.
        mode = 2'b01; up_dn = 1'b1; load = 1'b1; load_val = 4'd7;
        cycle();
        check("sat_load", count, 7);
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check($sformatf("sat_cnt%0d", i), count, sat_cnt[i]);
            check($sformatf("sat_evt%0d", i), evt, 0);
            check($sformatf("sat_tc%0d", i),  tc,  (sat_cnt[i] == 9));
        end

        // Load priority over a wrapping step, with clamp.
        mode = 2'b00; load = 1'b1; load_val = 4'd15;
        cycle();
        check("clamp_cnt", count, 9);
        check("clamp_evt", evt, 0);
        load_val = 4'd4;
        cycle();
        check("load4_cnt", count, 4);

        // One-shot from 0.
        mode = 2'b10; load_val = 4'd0;
        cycle();
        check("os_load", count, 0);
        load = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            cycle();
            check($sformatf("os_cnt%0d", i),  count, i);
            check($sformatf("os_done%0d", i), done, 0);
            check($sformatf("os_evt%0d", i),  evt, 0);
        end
        cycle();
        check("os_fin_cnt",  count, 9);
        check("os_fin_done", done, 1);
        check("os_fin_evt",  evt, 1);
        cycle();
        check("os_hold_cnt",  count, 9);
        check("os_hold_done", done, 1);
        check("os_hold_evt",  evt, 0);
        mode = 2'b00; en = 1'b0;
        cycle();
        check("os_sticky_done", done, 1);
        check("os_sticky_cnt",  count, 9);
        mode = 2'b10; load = 1'b1; load_val = 4'd3;
        cycle();
        check("os_reload_cnt",  count, 3);
        check("os_reload_done", done, 0);

        // Ping-pong: load 8 going up; up_dn is ignored while running.
        mode = 2'b11; load_val = 4'd8; up_dn = 1'b1;
        cycle();
        check("pp_load_cnt", count, 8);
        check("pp_load_dir", dir, 1);
        load = 1'b0; en = 1'b1; up_dn = 1'b0;
        cycle();
        check("pp_9_cnt", count, 9);
        check("pp_9_evt", evt, 0);
        check("pp_9_tc",  tc, 1);
        check("pp_9_dir", dir, 1);
        cycle();
        check("pp_8_cnt", count, 8);
        check("pp_8_evt", evt, 1);
        check("pp_8_dir", dir, 0);
        cycle();
        check("pp_7_cnt", count, 7);
        check("pp_7_evt", evt, 0);
        check("pp_7_dir", dir, 0);
        cycle();
        cycle();
        check("pp_5_cnt", count, 5);

        // Asynchronous reset mid-count, between clock edges.
        #2 reset = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_evt",   evt, 0);
        check("arst_done",  done, 0);
        check("arst_dir",   dir, 1);
        en = 1'b0;
        #2 reset = 1'b1;
        cycle();
        check("arst_hold", count, 0);

        // Ping-pong: load 1 going down, bounce at 0.
        load = 1'b1; load_val = 4'd1; up_dn = 1'b0;
        cycle();
        check("pp2_load_cnt", count, 1);
        check("pp2_load_dir", dir, 0);
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        cycle();
        check("pp2_0_cnt", count, 0);
        check("pp2_0_tc",  tc, 1);
        check("pp2_0_dir", dir, 0);
        cycle();
        check("pp2_1_cnt", count, 1);
        check("pp2_1_evt", evt, 1);
        check("pp2_1_dir", dir, 1);

        // Hold with en low; tc stays valid.
        en = 1'b0;
        cycle();
        check("hold_cnt", count, 1);
        check("hold_evt", evt, 0);
        check("hold_tc",  tc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_param_updown_counter

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised successor to the team's fixed 4-bit free-running counter. Generalised in width and modulus, with up/down counting, synchronous load, count enable, and four run modes: wrap, saturate, one-shot and ping-pong. It produces terminal-count and event flags for downstream sequencing and sits directly behind the tt_um top-level pin mux.

Parameters:
WIDTH, 4, counter width in bits (>=2)
MAX_VAL, 2**WIDTH-1, upper count bound inclusive; 1 <= MAX_VAL <= 2**WIDTH-1
PRESCALE_DIV, 4, clock-enable divide ratio (>=2); used only when PRESCALE_EN is defined

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-low reset; 0 = reset asserted
en  in  1  count enable
up_dn  in  1  direction: 1 = up, 0 = down; ignored in ping-pong mode except on load
mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 ping-pong
load  in  1  synchronous load strobe
load_val  in  WIDTH  load value
count  out  WIDTH  current count, registered
tc  out  1  combinational: count equals the terminal value for the effective direction
evt  out  1  registered one-cycle pulse on wrap, reversal, or one-shot completion
done  out  1  registered one-shot completion flag (sticky)
dir  out  1  effective direction currently in use (1 = up)

Behaviour:
- Reset (reset=0, async): count=0, evt=0, done=0, internal ping-pong direction register pp_dir=1 (up). Release is synchronous to clock.
- Effective direction: pp_dir in mode 11; up_dn otherwise. Terminal = MAX_VAL when up, 0 when down.
- Priority per cycle: load > step > hold.
- Load:
  - count <= min(load_val, MAX_VAL); done <= 0; pp_dir <= up_dn; evt <= 0.
  - Load ignores en and the tick.
- Step: occurs when en=1, tick=1 and not (mode=10 and done=1).
  - Not at terminal: count +/- 1; evt <= 0.
  - At terminal, mode 00: count jumps to the opposite bound (MAX_VAL->0 or 0->MAX_VAL); evt <= 1.
  - At terminal, mode 01: count holds; evt <= 0.
  - At terminal, mode 10: count holds; done <= 1; evt <= 1 only on the cycle done first sets.
  - At terminal, mode 11: pp_dir flips; count moves one step in the new direction (MAX_VAL->MAX_VAL-1, 0->1); evt <= 1.
- No step: count holds; evt <= 0.
- Out of range: count is never > MAX_VAL. Arithmetic is WIDTH bits and no intermediate overflow is exposed.
- Mode change mid-run: takes effect on the next step. Leaving mode 10 does not clear done; only load or reset clears it. Entering mode 11 keeps the current pp_dir.
- tc is valid every cycle, including while en=0.
- Latency: count updates on the clock edge after the qualifying inputs are sampled; evt aligns with that updated count.

Optional Feature:
- Macro PARAM_COUNTER_PRESCALE_EN.
- Defined: instantiate counter_prescaler. It emits tick=1 once every PRESCALE_DIV clocks while en=1; its internal divider is reset by reset=0 or load=1, and holds while en=0.
- Undefined: tick is tied to 1 and PRESCALE_DIV is unused.
- Port list is identical in both builds.

Decomposition:
- Package param_counter_pkg: mode localparams MODE_WRAP=2'b00, MODE_SAT=2'b01, MODE_ONESHOT=2'b10, MODE_PINGPONG=2'b11; direction constants DIR_UP=1'b1, DIR_DN=1'b0.
- Sub-module counter_prescaler (clock, reset, en, clr, tick) with parameter DIV. Exists only under the macro.
- Main module holds the count and pp_dir registers plus next-state logic.

Test Plan:
(Configuration for all: WIDTH=4, MAX_VAL=9, macro undefined.)
- Reset mid-count: pulse reset low at count=5 -> count=0, evt=0, done=0, dir=1 immediately, without waiting for a clock edge.
- Wrap up: mode 00, up_dn=1, en=1 for 12 clocks from 0 -> count 1..9,0,1,2; evt high exactly on the cycle count=0. Wrap down from 0 -> next count=9, evt=1.
- Saturate: mode 01, load 7, then up for 5 clocks -> 8,9,9,9,9; tc=1 from count=9; evt never high.
- One-shot: mode 10, load 0, up, en=1 -> reaches 9; done=1 and evt=1 for one cycle; further en holds at 9. load_val=3 -> count=3, done=0.
- Ping-pong: mode 11, load 8 with up_dn=1 -> 9,8,7; dir falls with evt=1 at the 9->8 step. Load 1 with up_dn=0 -> 0,1, dir rises.
- Load priority and clamp: load=1 and en=1 together with load_val=15 -> count=9, no step taken that cycle. With the macro and PRESCALE_DIV=4 -> count advances once per 4 enabled clocks.
